// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin N-master / S-slave bus arbiter with region decode and ready timeout
module bus_arbiter_rr #(
    parameter int                             NUM_MASTERS = 2,
    parameter int                             NUM_SLAVES  = 8,
    parameter int                             ADDR_W      = 32,
    parameter int                             DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE    = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_LIMIT   = '0,
    parameter int                             DBG_MASTER  = 1,
    parameter int                             TIMEOUT     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ds_cpu_halt,
    input  logic [NUM_MASTERS*ADDR_W-1:0]      m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0]      m_write_data,
    input  logic [NUM_MASTERS*2-1:0]           m_reqw,
    input  logic [NUM_MASTERS*2-1:0]           m_mode,
    input  logic [NUM_MASTERS-1:0]             m_reqs,
    output logic [DATA_W-1:0]                  m_read_data,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic [ADDR_W-1:0]                  slv_address,
    output logic [DATA_W-1:0]                  slv_write_data,
    output logic [1:0]                         slv_reqw,
    output logic [1:0]                         slv_mode,
    output logic                               slv_reqs,
    output logic [NUM_SLAVES-1:0]              slv_select,
    input  logic [NUM_SLAVES*DATA_W-1:0]       slv_read_data,
    input  logic [NUM_SLAVES-1:0]              slv_ready,
    output logic [$clog2(NUM_MASTERS)-1:0]     grant_idx,
    output logic                               busy
);
    localparam int MW = $clog2(NUM_MASTERS);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_MASTERS-1:0] DBG_MASK = NUM_MASTERS'(1) << DBG_MASTER;
    localparam logic [MW-1:0] PTR_RST = MW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [MW-1:0]           ptr_q, ptr_d, grant_q, grant_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]              reqw_q, reqw_d, mode_q, mode_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    err_q, err_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0]  elig;
    logic                    found, hit, ready_sel;
    logic [MW-1:0]           win, cand_idx;
    int                      cand;
    logic [ADDR_W-1:0]       win_addr;
    logic [DATA_W-1:0]       win_wdata, rd_sel;
    logic [1:0]              win_reqw, win_mode;
    logic [NUM_SLAVES-1:0]   dec;

    // Search starts one past the last winner so every master gets a turn.
    always_comb begin
        elig     = ds_cpu_halt ? (m_reqs & DBG_MASK) : m_reqs;
        found    = 1'b0;
        win      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
            cand_idx = MW'(cand);
            if (!found && elig[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_reqw  = '0;
        win_mode  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win == MW'(i)) begin
                win_addr  = m_address[i*ADDR_W +: ADDR_W];
                win_wdata = m_write_data[i*DATA_W +: DATA_W];
                win_reqw  = m_reqw[i*2 +: 2];
                win_mode  = m_mode[i*2 +: 2];
            end
        end
        hit = 1'b0;
        dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit && win_addr >= SLV_BASE[i*ADDR_W +: ADDR_W]
                     && win_addr <= SLV_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit    = 1'b1;
                dec[i] = 1'b1;
            end
        end
    end

    // sel_q is one-hot, so an OR of masked lanes is the selected slave's data.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) rd_sel = rd_sel | slv_read_data[i*DATA_W +: DATA_W];
        end
        ready_sel = |(slv_ready & sel_q);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        reqw_d  = reqw_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    ptr_d   = win;
                    grant_d = win;
                    addr_d  = win_addr;
                    wdata_d = win_wdata;
                    reqw_d  = win_reqw;
                    mode_d  = win_mode;
                    sel_d   = dec;
                    cnt_d   = '0;
                    err_d   = !hit;
                    state_d = hit ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (ready_sel) begin
                    rdata_d = rd_sel;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            reqw_q  <= '0;
            mode_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reqw_q  <= reqw_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign m_read_data    = rdata_q;
    assign m_ack          = (state_q == DONE) ? (NUM_MASTERS'(1) << grant_q) : '0;
    assign m_err          = (state_q == DONE && err_q) ? (NUM_MASTERS'(1) << grant_q) : '0;
    assign slv_address    = addr_q;
    assign slv_write_data = wdata_q;
    assign slv_reqw       = reqw_q;
    assign slv_mode       = mode_q;
    assign slv_reqs       = (state_q == ACCESS);
    assign slv_select     = sel_q;
    assign grant_idx      = grant_q;
    assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - self-checking bench for bus_arbiter_rr against a round-robin/memory-map model
module tb_bus_arbiter_rr;
    localparam int NM = 2, NS = 4, AW = 32, DW = 32, TO = 16, DBG = 1;
    localparam logic [31:0] RB [NS] = '{32'h0000_0000, 32'h0000_3000, 32'h0000_1000, 32'h0000_1800};
    localparam logic [31:0] RL [NS] = '{32'h0000_0FFF, 32'h0000_3FFF, 32'h0000_1FFF, 32'h0000_2FFF};

    logic clk = 1'b0, reset, ds_cpu_halt;
    logic [NM*AW-1:0] m_address;
    logic [NM*DW-1:0] m_write_data;
    logic [NM*2-1:0]  m_reqw, m_mode;
    logic [NM-1:0]    m_reqs, m_ack, m_err;
    logic [DW-1:0]    m_read_data, slv_write_data;
    logic [AW-1:0]    slv_address;
    logic [1:0]       slv_reqw, slv_mode;
    logic             slv_reqs, busy;
    logic [NS-1:0]    slv_select, slv_ready;
    logic [NS*DW-1:0] slv_read_data;
    logic [0:0]       grant_idx;

    bus_arbiter_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .SLV_BASE({RB[3], RB[2], RB[1], RB[0]}), .SLV_LIMIT({RL[3], RL[2], RL[1], RL[0]}),
        .DBG_MASTER(DBG), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .ds_cpu_halt(ds_cpu_halt), .m_address(m_address),
        .m_write_data(m_write_data), .m_reqw(m_reqw), .m_mode(m_mode), .m_reqs(m_reqs),
        .m_read_data(m_read_data), .m_ack(m_ack), .m_err(m_err), .slv_address(slv_address),
        .slv_write_data(slv_write_data), .slv_reqw(slv_reqw), .slv_mode(slv_mode),
        .slv_reqs(slv_reqs), .slv_select(slv_select), .slv_read_data(slv_read_data),
        .slv_ready(slv_ready), .grant_idx(grant_idx), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {
        int cyc; logic [NM-1:0] ack, err; logic [DW-1:0] rdata;
        logic [0:0] grant; logic [NS-1:0] sel; logic [AW-1:0] addr; bit saw;
    } rec_t;
    rec_t ack_q[$];

    int n_vec = 0, n_bad = 0, cyc = 0, acc = 0;
    int lat [NS];
    logic [DW-1:0] sdata [NS];
    bit noise_en = 1'b0;
    int mptr;
    logic [DW-1:0] mrdata;
    bit saw;
    logic [NS-1:0] sel_seen;
    logic [AW-1:0] addr_seen;

    always_comb begin
        slv_read_data = '0;
        for (int s = 0; s < NS; s++) slv_read_data[s*DW +: DW] = sdata[s];
    end

    // Slave model: selected slave answers on its programmed ACCESS cycle (0 = never).
    always @(posedge clk) begin : responder
        logic [NS-1:0] rdy;
        #2;
        acc = slv_reqs ? acc + 1 : 0;
        rdy = '0;
        for (int s = 0; s < NS; s++)
            if (slv_reqs && slv_select[s] && lat[s] != 0 && acc == lat[s]) rdy[s] = 1'b1;
        if (noise_en) rdy = rdy | (NS'($urandom) & ~slv_select);
        slv_ready = rdy;
    end

    always @(posedge clk) begin : monitor
        rec_t r;
        cyc = cyc + 1;
        #3;
        if (reset) saw = 1'b0;
        if (slv_reqs) begin saw = 1'b1; sel_seen = slv_select; addr_seen = slv_address; end
        if (|m_ack) begin
            r.cyc = cyc; r.ack = m_ack; r.err = m_err; r.rdata = m_read_data;
            r.grant = grant_idx; r.sel = saw ? sel_seen : '0; r.addr = addr_seen; r.saw = saw;
            ack_q.push_back(r);
            saw = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic step(); @(posedge clk); #4; endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && busy !== 1'b0; k++) step();
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && ack_q.size() < n; k++) step();
        ok = (ack_q.size() >= n);
    endtask

    task automatic set_master(input int m, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] w, input logic [1:0] md);
        m_address[m*AW +: AW] = a; m_write_data[m*DW +: DW] = d;
        m_reqw[m*2 +: 2] = w; m_mode[m*2 +: 2] = md;
    endtask

    function automatic int region_of(input logic [31:0] a);
        for (int i = 0; i < NS; i++) if (RB[i] <= a && a <= RL[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ds_cpu_halt = 0; m_reqs = '0; m_address = '0; m_write_data = '0;
        m_reqw = '0; m_mode = '0; slv_ready = '0;
        for (int s = 0; s < NS; s++) begin lat[s] = 1; sdata[s] = '0; end
        #1;
        n_vec++;
        if ({m_ack, m_err, m_read_data, slv_reqs, slv_select, grant_idx, busy} !== '0) begin
            n_bad++; $display("FAIL reset_ctl ack=%b err=%b rd=%h reqs=%b sel=%b g=%b busy=%b exp all 0",
                m_ack, m_err, m_read_data, slv_reqs, slv_select, grant_idx, busy);
        end
        n_vec++;
        if ({slv_address, slv_write_data, slv_reqw, slv_mode} !== '0) begin
            n_bad++; $display("FAIL reset_fields addr=%h wd=%h w=%b m=%b exp 0",
                slv_address, slv_write_data, slv_reqw, slv_mode);
        end
        step(); step();
        reset = 1'b0; mptr = NM - 1; mrdata = '0;
        step();
    endtask

    task automatic test_single();
        bit ok; int c;
        wait_idle(); ack_q.delete();
        lat[1] = 3; sdata[1] = 32'hDEAD_BEEF;
        set_master(0, 32'h3004, 32'hA5A5_0001, 2'b10, 2'b01);
        m_reqs = 2'b01; c = cyc;
        step();
        n_vec++;
        if ({slv_reqs, slv_select, slv_write_data, slv_reqw, slv_mode, grant_idx} !==
            {1'b1, 4'b0010, 32'hA5A5_0001, 2'b10, 2'b01, 1'b0}) begin
            n_bad++; $display("FAIL single_latch reqs=%b sel=%b wd=%h w=%b m=%b g=%b exp 1 0010 a5a50001 10 01 0",
                slv_reqs, slv_select, slv_write_data, slv_reqw, slv_mode, grant_idx);
        end
        set_master(0, 32'h0000_0004, 32'h1111_2222, 2'b00, 2'b11);
        m_reqs = 2'b00;
        wait_acks(1, 30, ok);
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL single_ack got=none exp=ack"); end
        else begin
            n_vec++;
            if ({ack_q[0].ack, ack_q[0].err, ack_q[0].rdata, ack_q[0].sel, ack_q[0].addr} !==
                {2'b01, 2'b00, 32'hDEAD_BEEF, 4'b0010, 32'h3004}) begin
                n_bad++; $display("FAIL single_result ack=%b err=%b rd=%h sel=%b addr=%h exp 01 00 deadbeef 0010 3004",
                    ack_q[0].ack, ack_q[0].err, ack_q[0].rdata, ack_q[0].sel, ack_q[0].addr);
            end
            n_vec++;
            if (ack_q[0].cyc - c !== 4) begin
                n_bad++; $display("FAIL single_latency got=%0d exp=4", ack_q[0].cyc - c);
            end
        end
        mptr = 0; mrdata = 32'hDEAD_BEEF;
        step(); step();
        n_vec++;
        if (busy !== 1'b0 || ack_q.size() != 1) begin
            n_bad++; $display("FAIL single_no_retrigger busy=%b acks=%0d exp 0 1", busy, ack_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int c, w;
        wait_idle(); ack_q.delete();
        for (int s = 0; s < NS; s++) begin lat[s] = 1; sdata[s] = $urandom; end
        set_master(0, 32'h0010, 32'h0, 2'b10, 2'b00);
        set_master(1, 32'h1004, 32'h0, 2'b10, 2'b00);
        m_reqs = 2'b11; c = cyc;
        wait_acks(4, 40, ok);
        m_reqs = 2'b00;
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL b2b_count got=%0d exp=4", ack_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            w = (mptr + 1) % NM; mptr = w;
            mrdata = sdata[w == 0 ? 0 : 2];
            n_vec++;
            if (ack_q[i].ack !== NM'(1 << w) || ack_q[i].rdata !== mrdata || ack_q[i].err !== '0) begin
                n_bad++; $display("FAIL b2b_grant i=%0d ack=%b rd=%h err=%b exp ack=%b rd=%h err=00",
                    i, ack_q[i].ack, ack_q[i].rdata, ack_q[i].err, NM'(1 << w), mrdata);
            end
            n_vec++;
            if (ack_q[i].cyc - c !== 2 + 3 * i) begin
                n_bad++; $display("FAIL b2b_spacing i=%0d got=%0d exp=%0d", i, ack_q[i].cyc - c, 2 + 3 * i);
            end
        end
    endtask

    task automatic test_halt();
        bit ok, any_busy; int c;
        wait_idle(); ack_q.delete();
        ds_cpu_halt = 1'b1; m_reqs = 2'b01; any_busy = 0;
        for (int k = 0; k < 5; k++) begin step(); any_busy |= busy; end
        n_vec++;
        if (any_busy || ack_q.size() != 0) begin
            n_bad++; $display("FAIL halt_block busy=%b acks=%0d exp 0 0", any_busy, ack_q.size());
        end
        m_reqs = 2'b11; c = cyc;
        wait_acks(3, 40, ok);
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL halt_count got=%0d exp=3", ack_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (ack_q[i].ack !== 2'b10 || ack_q[i].cyc - c !== 2 + 3 * i) begin
                n_bad++; $display("FAIL halt_grant i=%0d ack=%b dt=%0d exp ack=10 dt=%0d",
                    i, ack_q[i].ack, ack_q[i].cyc - c, 2 + 3 * i);
            end
        end
        mptr = DBG; mrdata = sdata[2];
        ds_cpu_halt = 1'b0; ack_q.delete();
        wait_acks(1, 20, ok);
        m_reqs = 2'b00;
        n_vec++;
        if (!ok || ack_q[0].ack !== 2'b01) begin
            n_bad++; $display("FAIL halt_release ack=%b exp=01", ok ? ack_q[0].ack : 2'b00);
        end
        mptr = 0; mrdata = sdata[0];
        wait_idle(); ack_q.delete();
        lat[0] = 5; m_reqs = 2'b01; c = cyc;
        step(); step();
        ds_cpu_halt = 1'b1;
        wait_acks(1, 20, ok);
        m_reqs = 2'b00; ds_cpu_halt = 1'b0;
        n_vec++;
        if (!ok || ack_q[0].ack !== 2'b01 || ack_q[0].err !== 2'b00 || ack_q[0].cyc - c !== 6) begin
            n_bad++; $display("FAIL halt_mid ok=%b ack=%b err=%b dt=%0d exp 1 01 00 6",
                ok, ok ? ack_q[0].ack : 2'b00, ok ? ack_q[0].err : 2'b00, ok ? ack_q[0].cyc - c : -1);
        end
        mrdata = sdata[0];
    endtask

    task automatic test_decode_err();
        bit ok; int c;
        wait_idle(); ack_q.delete();
        set_master(0, 32'h5000, 32'h0, 2'b00, 2'b00);
        m_reqs = 2'b01; c = cyc;
        wait_acks(1, 10, ok);
        m_reqs = 2'b00;
        n_vec++;
        if (!ok) begin n_bad++; $display("FAIL decerr_ack got=none exp=ack"); end
        else begin
            n_vec++;
            if ({ack_q[0].ack, ack_q[0].err, ack_q[0].saw, ack_q[0].rdata} !== {2'b01, 2'b01, 1'b0, mrdata}) begin
                n_bad++; $display("FAIL decerr_result ack=%b err=%b saw_reqs=%b rd=%h exp 01 01 0 %h",
                    ack_q[0].ack, ack_q[0].err, ack_q[0].saw, ack_q[0].rdata, mrdata);
            end
            n_vec++;
            if (ack_q[0].cyc - c !== 1) begin
                n_bad++; $display("FAIL decerr_latency got=%0d exp=1", ack_q[0].cyc - c);
            end
        end
        mptr = 0;
    endtask

    task automatic test_timeout();
        bit ok; int c;
        wait_idle(); ack_q.delete();
        lat[0] = 0; set_master(1, 32'h0100, 32'h0, 2'b00, 2'b00);
        m_reqs = 2'b10; c = cyc;
        wait_acks(1, TO + 10, ok);
        m_reqs = 2'b00;
        n_vec++;
        if (!ok || {ack_q[0].ack, ack_q[0].err, ack_q[0].rdata} !== {2'b10, 2'b10, 32'h0}) begin
            n_bad++; $display("FAIL timeout_result ok=%b ack=%b err=%b rd=%h exp 1 10 10 0",
                ok, ok ? ack_q[0].ack : 2'b00, ok ? ack_q[0].err : 2'b00, ok ? ack_q[0].rdata : 32'h0);
        end
        n_vec++;
        if (ok && ack_q[0].cyc - c !== TO + 1) begin
            n_bad++; $display("FAIL timeout_latency got=%0d exp=%0d", ack_q[0].cyc - c, TO + 1);
        end
        mptr = 1; mrdata = '0;
    endtask

    task automatic test_random();
        bit ok; int c, w, r, L, idx;
        logic [NM-1:0] reqs, elig, e_ack, e_err;
        logic [31:0] addr [NM];
        logic [31:0] pool [13] = '{32'h0000, 32'h0FFF, 32'h1000, 32'h17FC, 32'h1800, 32'h1FFF,
            32'h2000, 32'h2FFF, 32'h3000, 32'h3FFF, 32'h4000, 32'h5000, 32'hFFFF_FFFF};
        logic [DW-1:0] e_rd; logic [NS-1:0] e_sel;
        for (int it = 0; it < 60; it++) begin
            wait_idle(); ack_q.delete();
            for (int m = 0; m < NM; m++) begin
                idx = $urandom_range(0, 13);
                addr[m] = (idx == 13) ? $urandom : pool[idx];
                set_master(m, addr[m], $urandom, 2'($urandom), 2'($urandom));
            end
            for (int s = 0; s < NS; s++) begin
                lat[s] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
                sdata[s] = $urandom;
            end
            noise_en = 1'($urandom);
            ds_cpu_halt = ($urandom_range(0, 3) == 0);
            reqs = NM'($urandom_range(0, 3));
            elig = ds_cpu_halt ? (reqs & NM'(1 << DBG)) : reqs;
            m_reqs = reqs; c = cyc;
            if (elig == '0) begin
                for (int k = 0; k < 4; k++) step();
                m_reqs = '0; ds_cpu_halt = 0;
                n_vec++;
                if (ack_q.size() != 0 || busy !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_idle it=%0d acks=%0d busy=%b exp 0 0", it, ack_q.size(), busy);
                end
                continue;
            end
            w = -1;
            for (int i = 1; i <= NM; i++) if (w < 0 && elig[(mptr + i) % NM]) w = (mptr + i) % NM;
            mptr = w;
            r = region_of(addr[w]);
            e_ack = NM'(1 << w);
            if (r < 0) begin L = 0; e_err = e_ack; e_rd = mrdata; e_sel = '0; end
            else if (lat[r] == 0) begin L = TO; e_err = e_ack; e_rd = '0; e_sel = NS'(1 << r); end
            else begin L = lat[r]; e_err = '0; e_rd = sdata[r]; e_sel = NS'(1 << r); end
            mrdata = e_rd;
            wait_acks(1, TO + 8, ok);
            m_reqs = '0; ds_cpu_halt = 0;
            n_vec++;
            if (!ok) begin n_bad++; $display("FAIL rnd_ack it=%0d got=none exp=%b", it, e_ack); continue; end
            n_vec++;
            if ({ack_q[0].ack, ack_q[0].err, ack_q[0].grant} !== {e_ack, e_err, 1'(w)}) begin
                n_bad++; $display("FAIL rnd_grant it=%0d ack=%b err=%b g=%b exp %b %b %0d",
                    it, ack_q[0].ack, ack_q[0].err, ack_q[0].grant, e_ack, e_err, w);
            end
            n_vec++;
            if (ack_q[0].rdata !== e_rd || ack_q[0].sel !== e_sel || ack_q[0].saw !== (r >= 0)) begin
                n_bad++; $display("FAIL rnd_data it=%0d rd=%h sel=%b saw=%b exp %h %b %b",
                    it, ack_q[0].rdata, ack_q[0].sel, ack_q[0].saw, e_rd, e_sel, r >= 0);
            end
            n_vec++;
            if (ack_q[0].cyc - c !== L + 1 || (r >= 0 && ack_q[0].addr !== addr[w])) begin
                n_bad++; $display("FAIL rnd_timing it=%0d dt=%0d addr=%h exp %0d %h",
                    it, ack_q[0].cyc - c, ack_q[0].addr, L + 1, addr[w]);
            end
        end
        noise_en = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_idle(); ack_q.delete();
        lat[1] = 0; set_master(1, 32'h3000, 32'hCAFE_0000, 2'b11, 2'b10);
        m_reqs = 2'b10;
        step(); step(); step();
        n_vec++;
        if (slv_reqs !== 1'b1 || grant_idx !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_pre reqs=%b g=%b exp 1 1", slv_reqs, grant_idx);
        end
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if ({m_ack, m_err, m_read_data, slv_address, slv_write_data, slv_reqw, slv_mode,
             slv_reqs, slv_select, grant_idx, busy} !== '0) begin
            n_bad++; $display("FAIL rstmid_async reqs=%b sel=%b addr=%h g=%b busy=%b exp all 0",
                slv_reqs, slv_select, slv_address, grant_idx, busy);
        end
        step();
        reset = 1'b0; mptr = NM - 1; mrdata = '0; ack_q.delete();
        for (int s = 0; s < NS; s++) lat[s] = 1;
        set_master(0, 32'h0020, 32'h0, 2'b00, 2'b00);
        m_reqs = 2'b11;
        wait_acks(1, 10, ok);
        m_reqs = 2'b00;
        n_vec++;
        if (!ok || ack_q[0].ack !== 2'b01) begin
            n_bad++; $display("FAIL rstmid_priority ack=%b exp=01", ok ? ack_q[0].ack : 2'b00);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_halt();
        test_decode_err();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
